link_credit_rx: RTL and testbench

- Receiving end of a repeated, credit-flow-controlled point-to-point link.
- Upstream, a transmitter drives data through a chain of buffer/register repeater stages; it may only send while it holds credits.
- This block absorbs arriving words in a first-word-fall-through FIFO and returns one credit pulse per freed entry.
- After reset it issues the initial credit grant, then presents words downstream on a valid/ready interface.

---
 rtl/link_credit_pkg.sv | 17 +
 rtl/link_credit_rx_if.sv | 39 +++
 rtl/link_rx_fifo.sv | 54 +++++
 rtl/link_credit_rx.sv | 115 +++++++++++
 tb/tb_link_credit_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_credit_pkg.sv
// link_credit_rx shared types and helpers
// FSM states, credit pulse width and counter sizing
package link_credit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_t;

    localparam int CREDIT_W = 1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/link_credit_rx_if.sv
// link_credit_rx link/handshake bundle
// slave side is the receiver, master side is its environment
interface link_credit_rx_if #(
    parameter int WIDTH = 32
);
    import link_credit_pkg::*;

    logic                in_valid;
    logic [WIDTH-1:0]    in_data;
    logic [CREDIT_W-1:0] credit_out;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic                out_ready;
    logic                overflow;
    logic                init_done;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  credit_out,
        input  out_valid,
        input  out_data,
        input  overflow,
        input  init_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output credit_out,
        output out_valid,
        output out_data,
        output overflow,
        output init_done
    );

endinterface

// File: rtl/link_rx_fifo.sv
// link_rx_fifo: first-word-fall-through storage
// caller guarantees no push when full without pop, no pop when empty
module link_rx_fifo
    import link_credit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // head drives zero while empty so reset leaves the bus quiet
    assign rdata = empty ? '0 : mem[rd_ptr];

    // pointers wrap naturally; count tracks net push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // storage array, not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/link_credit_rx.sv
// link_credit_rx: credit-flow receiver end of a repeated link
// grants DEPTH credits after reset, then one credit per freed entry
module link_credit_rx
    import link_credit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    link_credit_rx_if.slave bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   SAT_MAX   = (CNT_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    init_cnt;
    logic [CNT_W-1:0]    init_cnt_next;
    logic [CNT_W-1:0]    pend;
    logic [CNT_W-1:0]    pend_next;
    logic [CNT_W:0]      total;
    logic                credit_next;
    logic [CREDIT_W-1:0] credit_q;
    logic                done_q;
    logic                ovf_q;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                drop;

    assign bus.out_valid  = !empty;
    assign bus.credit_out = credit_q;
    assign bus.init_done  = done_q;
    assign bus.overflow   = ovf_q;

    assign pop  = !empty && bus.out_ready;
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    link_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (bus.out_data),
        .full  (full),
        .empty (empty)
    );

    // grant sequencing and credit return decision
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        pend_next     = pend;
        credit_next   = 1'b0;
        total         = {1'b0, pend} + (CNT_W + 1)'(pop);
        unique case (state)
            IDLE: begin
                state_next    = INIT;
                init_cnt_next = '0;
            end
            INIT: begin
                init_cnt_next = init_cnt + CNT_W'(1);
                if (init_cnt == LAST_INIT)
                    state_next = RUN;
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_next == INIT) begin
            // grant pulses occupy the line; bank freed entries
            credit_next = 1'b1;
            if (total > SAT_MAX)
                pend_next = CNT_W'(DEPTH);
            else
                pend_next = total[CNT_W-1:0];
        end else if (total != '0) begin
            // one pulse per cycle, banked credits first
            credit_next = 1'b1;
            pend_next   = CNT_W'(total - (CNT_W + 1)'(1));
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            init_cnt <= '0;
            pend     <= '0;
            credit_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
            pend     <= pend_next;
            credit_q <= CREDIT_W'(credit_next);
            done_q   <= (state_next == RUN);
            ovf_q    <= ovf_q | drop;
        end
    end

endmodule

// File: tb/tb_link_credit_rx.sv
// tb_link_credit_rx: scenario tasks plus randomized traffic
// checked against a queue-based model of the receiver
module tb_link_credit_rx;
    import link_credit_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    link_credit_rx_if #(.WIDTH(WIDTH)) bus ();

    link_credit_rx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mq[$];
    int          m_edges;
    int          m_pend;
    bit          m_cr;
    bit          m_ovf;
    bit          m_done;

    function automatic logic [31:0] exp_head();
        if (mq.size() != 0) return mq[0];
        return 32'h0;
    endfunction

    function automatic logic [35:0] exp_bundle();
        return {m_cr, mq.size() != 0, m_ovf, m_done, exp_head()};
    endfunction

    function automatic logic [35:0] act_bundle();
        logic [31:0] d;
        d = bus.out_valid ? bus.out_data : 32'h0;
        return {bus.credit_out, bus.out_valid, bus.overflow,
                bus.init_done, d};
    endfunction

    // edge n (counted from reset release): edges 1..DEPTH
    // carry the initial grant, later edges return credits
    task automatic model_edge(input logic iv, input logic [31:0] d,
                              input logic rdy);
        bit v, p, full;
        int n, t;
        v    = (mq.size() != 0);
        p    = v && rdy;
        full = (mq.size() == DEPTH);
        n    = m_edges + 1;
        if (p) void'(mq.pop_front());
        if (iv) begin
            if (!full || p) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        if (n <= DEPTH) begin
            m_cr   = 1'b1;
            t      = m_pend + int'(p);
            m_pend = (t > DEPTH) ? DEPTH : t;
        end else begin
            t      = m_pend + int'(p);
            m_cr   = (t > 0);
            m_pend = (t > 0) ? t - 1 : 0;
        end
        m_done  = (n > DEPTH);
        m_edges = n;
    endtask

    task automatic cyc(input logic iv, input logic [31:0] d,
                       input logic rdy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        model_edge(iv, d, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        mq.delete();
        m_edges = 0;
        m_pend  = 0;
        m_cr    = 1'b0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_idle(input int n);
        repeat (n) cyc(1'b0, $urandom, 1'b0);
    endtask

    task automatic test_reset();
        int pulses;
        logic [35:0] a;
        do_reset();
        a = {bus.credit_out, bus.out_valid, bus.overflow,
             bus.init_done, bus.out_data};
        vectors++;
        if (a !== 36'h0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", a);
        end
        pulses = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            cyc(1'b0, $urandom, 1'($urandom));
            if (bus.credit_out === 1'b1) pulses++;
            vectors++;
            if (act_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL init_cycle%0d got=%h exp=%h",
                         i, act_bundle(), exp_bundle());
            end
        end
        vectors++;
        if (pulses !== DEPTH) begin
            errors++;
            $display("FAIL init_pulses got=%0d exp=%0d", pulses, DEPTH);
        end
        vectors++;
        if (bus.init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done got=%b exp=1", bus.init_done);
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        w = 32'hA5A5A5A5;
        cyc(1'b1, w, 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== w) begin
            errors++;
            $display("FAIL single_head got=%b/%h exp=1/%h",
                     bus.out_valid, bus.out_data, w);
        end
        cyc(1'b0, $urandom, 1'b1);
        vectors++;
        if (bus.credit_out !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_credit got=%b/%b exp=1/0",
                     bus.credit_out, bus.out_valid);
        end
        cyc(1'b0, $urandom, 1'b1);
        vectors++;
        if (act_bundle() !== exp_bundle()) begin
            errors++;
            $display("FAIL single_after got=%h exp=%h",
                     act_bundle(), exp_bundle());
        end
    endtask

    task automatic test_overflow();
        int pulses;
        do_reset();
        run_idle(DEPTH + 1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b0);
        vectors++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got=%b exp=0", bus.overflow);
        end
        cyc(1'b1, 32'h5, 1'b0);
        vectors++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got=%b exp=1", bus.overflow);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.out_data !== 32'(i + 1)) begin
                errors++;
                $display("FAIL ovf_drain%0d got=%h exp=%h",
                         i, bus.out_data, i + 1);
            end
            cyc(1'b0, $urandom, 1'b1);
            if (bus.credit_out === 1'b1) pulses++;
        end
        cyc(1'b0, $urandom, 1'b1);
        if (bus.credit_out === 1'b1) pulses++;
        vectors++;
        if (pulses !== 4 || bus.overflow !== 1'b1 ||
            bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_end pulses=%0d ovf=%b v=%b exp=4/1/0",
                     pulses, bus.overflow, bus.out_valid);
        end
    endtask

    task automatic test_full_simul();
        logic [31:0] w[4];
        logic [31:0] seq[4];
        do_reset();
        run_idle(DEPTH + 1);
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            cyc(1'b1, w[i], 1'b0);
        end
        cyc(1'b1, 32'h9, 1'b1);
        vectors++;
        if (bus.overflow !== 1'b0 || bus.out_data !== w[1]) begin
            errors++;
            $display("FAIL full_simul got=%b/%h exp=0/%h",
                     bus.overflow, bus.out_data, w[1]);
        end
        seq = '{w[1], w[2], w[3], 32'h9};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== seq[i]) begin
                errors++;
                $display("FAIL full_drain%0d got=%b/%h exp=1/%h",
                         i, bus.out_valid, bus.out_data, seq[i]);
            end
            cyc(1'b0, $urandom, 1'b1);
        end
        vectors++;
        if (act_bundle() !== exp_bundle()) begin
            errors++;
            $display("FAIL full_end got=%h exp=%h",
                     act_bundle(), exp_bundle());
        end
    endtask

    task automatic test_init_pop();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) cyc(1'b1, 32'h77, 1'b1);
            else cyc(1'b0, $urandom, 1'b1);
            if (bus.credit_out === 1'b1) pulses++;
            vectors++;
            if (act_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL init_pop_cyc%0d got=%h exp=%h",
                         i, act_bundle(), exp_bundle());
            end
            if (i == 4) begin
                vectors++;
                if (bus.credit_out !== 1'b1 ||
                    bus.init_done !== 1'b1) begin
                    errors++;
                    $display("FAIL init_pop_run1 got=%b/%b exp=1/1",
                             bus.credit_out, bus.init_done);
                end
            end
        end
        vectors++;
        if (pulses !== DEPTH + 1) begin
            errors++;
            $display("FAIL init_pop_pulses got=%0d exp=%0d",
                     pulses, DEPTH + 1);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        logic [35:0] a;
        do_reset();
        run_idle(DEPTH + 1);
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0);
        #2 rst = 1'b1;
        #1;
        a = {bus.credit_out, bus.out_valid, bus.overflow,
             bus.init_done, bus.out_data};
        vectors++;
        if (a !== 36'h0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", a);
        end
        do_reset();
        pulses = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cyc(1'b0, $urandom, 1'b1);
            if (bus.credit_out === 1'b1) pulses++;
            vectors++;
            if (act_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL regrant_cyc%0d got=%h exp=%h",
                         i, act_bundle(), exp_bundle());
            end
        end
        vectors++;
        if (pulses !== DEPTH || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL regrant pulses=%0d v=%b exp=%0d/0",
                     pulses, bus.out_valid, DEPTH);
        end
    endtask

    task automatic test_random();
        logic iv;
        logic rdy;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (i > 200 && i < 260) rdy = 1'b0;
            cyc(iv, $urandom, rdy);
            vectors++;
            if (act_bundle() !== exp_bundle()) begin
                errors++;
                $display("FAIL random_cyc%0d got=%h exp=%h",
                         i, act_bundle(), exp_bundle());
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_full_simul();
        test_init_pop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
